// File: rtl/expr_eval.sv
// Streaming checker/evaluator for D([+*]D)*'=' expressions, '*' over '+'.
// Optional '-' operator when EXPR_SUB_EN is defined.
module expr_eval #(
    parameter int WIDTH   = 32,
    parameter int MAX_LEN = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_legal,
    output logic [WIDTH-1:0] out_value,
    output logic             busy
);

    localparam int LW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        OPND,
        OPER,
        ERR,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_MUL,
        OP_SUB
    } op_t;

    state_t state;
    op_t op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] term;
    logic [LW-1:0] len;

    logic accept;
    logic is_dig;
    logic is_eq;
    logic is_add;
    logic is_mul;
    logic is_sub;
    logic full;
    logic [WIDTH-1:0] dval;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] neg;

    assign in_ready = (state != DONE);
    assign busy = (state == OPND) || (state == OPER) || (state == ERR);
    assign accept = in_valid && in_ready;

    assign is_dig = (in_char >= 8'h30) && (in_char <= 8'h39);
    assign is_eq = (in_char == 8'h3d);
    assign is_add = (in_char == 8'h2b);
    assign is_mul = (in_char == 8'h2a);
`ifdef EXPR_SUB_EN
    assign is_sub = (in_char == 8'h2d);
`else
    assign is_sub = 1'b0;
`endif

    // Low nibble of an ASCII digit is its value.
    assign dval = {{(WIDTH-4){1'b0}}, in_char[3:0]};
    assign prod = term * dval;
    assign neg = '0 - dval;
    assign full = (len == LW'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op <= OP_ADD;
            sum <= '0;
            term <= '0;
            len <= '0;
            out_valid <= 1'b0;
            out_legal <= 1'b0;
            out_value <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == DONE) begin
                state <= IDLE;
                len <= '0;
            end else if (accept) begin
                if (is_eq) begin
                    state <= DONE;
                    out_valid <= 1'b1;
                    if (state == OPND) begin
                        out_legal <= 1'b1;
                        out_value <= sum + term;
                    end else begin
                        out_legal <= 1'b0;
                        out_value <= '0;
                    end
                end else if (full) begin
                    state <= ERR;
                end else begin
                    len <= len + LW'(1);
                    unique case (state)
                        IDLE: begin
                            if (is_dig) begin
                                state <= OPND;
                                term <= dval;
                                sum <= '0;
                            end else begin
                                state <= ERR;
                            end
                        end
                        OPND: begin
                            unique case (1'b1)
                                is_add: begin
                                    state <= OPER;
                                    sum <= sum + term;
                                    op <= OP_ADD;
                                end
                                is_sub: begin
                                    state <= OPER;
                                    sum <= sum + term;
                                    op <= OP_SUB;
                                end
                                is_mul: begin
                                    state <= OPER;
                                    op <= OP_MUL;
                                end
                                default: state <= ERR;
                            endcase
                        end
                        OPER: begin
                            if (is_dig) begin
                                state <= OPND;
                                unique case (op)
                                    OP_MUL: term <= prod;
                                    OP_SUB: term <= neg;
                                    default: term <= dval;
                                endcase
                            end else begin
                                state <= ERR;
                            end
                        end
                        default: state <= ERR;
                    endcase
                end
            end
        end
    end

endmodule
